// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned multiply and divide.
// Optional macro ALU_MC_DIV_EN enables the restoring divider (divu, code 1001).
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUctr,
    output logic [WIDTH-1:0] ALU,
    output logic [WIDTH-1:0] hi,
    output logic             Zero,
    output logic             carrier,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1001;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;
    logic [WIDTH-1:0] alu_q, alu_d, hi_q, hi_d;
    logic             zero_q, zero_d, carrier_q, carrier_d;
    logic             busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
    logic             is_div_q, is_div_d;

    logic [WIDTH:0]   a_ext_s, b_ext_s, sum_s;
    logic [WIDTH-1:0] sc_res_s, it_hi_s, it_lo_s;
    logic             sc_carry_s, mc_op_s, div0_s;
    logic [WIDTH:0]   mul_sum_s;
`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   div_shift_s, div_diff_s;
    logic             div_ge_s;
`endif

    // Single-cycle result and carry; add/sub/or are evaluated at WIDTH+1 bits sign-extended
    always_comb begin
        a_ext_s    = {A[WIDTH-1], A};
        b_ext_s    = {B[WIDTH-1], B};
        sum_s      = '0;
        sc_res_s   = B;
        sc_carry_s = 1'b0;
        case (ALUctr)
            OP_ADD: begin
                sum_s      = a_ext_s + b_ext_s;
                sc_res_s   = sum_s[WIDTH-1:0];
                sc_carry_s = sum_s[WIDTH];
            end
            OP_SUB: begin
                sum_s      = a_ext_s - b_ext_s;
                sc_res_s   = sum_s[WIDTH-1:0];
                sc_carry_s = sum_s[WIDTH];
            end
            OP_OR: begin
                sum_s      = a_ext_s | b_ext_s;
                sc_res_s   = sum_s[WIDTH-1:0];
                sc_carry_s = sum_s[WIDTH];
            end
            OP_AND:  sc_res_s = A & B;
            OP_XOR:  sc_res_s = A ^ B;
            OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  sc_res_s = A << B[SH_W-1:0];
            OP_SRL:  sc_res_s = A >> B[SH_W-1:0];
            default: sc_res_s = B;
        endcase
    end

    // Op classification at acceptance; a zero divisor bypasses the iterative path
`ifdef ALU_MC_DIV_EN
    assign mc_op_s = (ALUctr == OP_MULU) || ((ALUctr == OP_DIVU) && (B != '0));
    assign div0_s  = (ALUctr == OP_DIVU) && (B == '0);
`else
    assign mc_op_s = (ALUctr == OP_MULU);
    assign div0_s  = 1'b0;
`endif

    // One iteration: shift-add multiply on {acc_hi,acc_lo}, or restoring divide step
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        it_hi_s   = mul_sum_s[WIDTH:1];
        it_lo_s   = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        div_shift_s = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        div_ge_s    = (div_shift_s >= {1'b0, b_q});
        if (is_div_q) begin
            it_hi_s = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
            it_lo_s = {acc_lo_q[WIDTH-2:0], div_ge_s};
        end else begin
            it_hi_s = mul_sum_s[WIDTH:1];
        end
`endif
    end

    // Next-state and output-register update; outputs hold until the next done
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        b_d        = b_q;
        is_div_d   = is_div_q;
        alu_d      = alu_q;
        hi_d       = hi_q;
        carrier_d  = carrier_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;
        busy_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mc_op_s) begin
                        state_d  = S_CALC;
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        acc_lo_d = A;
                        b_d      = B;
                        is_div_d = (ALUctr != OP_MULU);
                        busy_d   = 1'b1;
                    end else if (div0_s) begin
                        state_d    = S_DONE;
                        alu_d      = '1;
                        hi_d       = A;
                        carrier_d  = 1'b0;
                        div_zero_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = S_DONE;
                        alu_d      = sc_res_s;
                        hi_d       = '0;
                        carrier_d  = sc_carry_s;
                        div_zero_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                busy_d   = 1'b1;
                cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                acc_hi_d = it_hi_s;
                acc_lo_d = it_lo_s;
                if (cnt_q == LAST_CNT) begin
                    state_d    = S_DONE;
                    cnt_d      = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    alu_d      = it_lo_s;
                    hi_d       = it_hi_s;
                    carrier_d  = 1'b0;
                    div_zero_d = 1'b0;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        zero_d = (alu_d == '0);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            b_q        <= '0;
            is_div_q   <= 1'b0;
            alu_q      <= '0;
            hi_q       <= '0;
            zero_q     <= 1'b1;
            carrier_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            b_q        <= b_d;
            is_div_q   <= is_div_d;
            alu_q      <= alu_d;
            hi_q       <= hi_d;
            zero_q     <= zero_d;
            carrier_q  <= carrier_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign ALU      = alu_q;
    assign hi       = hi_q;
    assign Zero     = zero_q;
    assign carrier  = carrier_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the datapath. It keeps the single-cycle add/sub/or encodings and flag semantics, and adds and/xor/slt/shifts plus an iterative unsigned multiply and divide. Operands are captured on a start/done handshake. The control unit stalls on busy while a multi-cycle op runs.

Parameters:
WIDTH, 32, operand/result width (>=4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
A  in  WIDTH  first operand
B  in  WIDTH  second operand
ALUctr  in  4  operation select
ALU  out  WIDTH  result (low word / quotient)
hi  out  WIDTH  high product word / remainder; 0 for other ops
Zero  out  1  ALU==0
carrier  out  1  bit WIDTH of the (WIDTH+1)-bit sign-extended add/sub/or; 0 otherwise
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse, result valid
div_zero  out  1  set with done when divu has B==0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: ALU=0, hi=0, Zero=1, carrier=0, busy=0, done=0, div_zero=0, state IDLE, counter 0.
- Encodings:
  - 0010 add, 0110 sub, 0001 or
  - 0000 and, 0011 xor, 0111 slt (signed, result 1 or 0)
  - 0100 sll, 0101 srl (shift by B[log2(WIDTH)-1:0])
  - 1000 mulu, 1001 divu
  - any other code: ALU=B
- States:
  - IDLE: start=1 latches A, B and ALUctr. Single-cycle ops go to DONE. mulu/divu go to CALC with counter=0.
  - CALC: one iteration per cycle. Counter increments; after WIDTH iterations go to DONE. busy=1.
  - DONE: registers ALU/hi/flags, done=1 for one cycle, returns to IDLE.
- Latency from start to done: single-cycle ops 1 cycle; mulu/divu WIDTH+1 cycles; divu with B==0 1 cycle.
- Outputs hold their last value until the next done. start outside IDLE is ignored (no queueing). Operand changes after acceptance have no effect.
- mulu: shift-add on the 2*WIDTH product {hi,ALU}. Unsigned.
- divu: restoring division. ALU=quotient, hi=remainder. B==0 → ALU=all ones, hi=A, div_zero=1, skips CALC.
- carrier/Zero are computed exactly as a (WIDTH+1)-bit sign-extended operation for add/sub/or. Zero tracks ALU for all ops.
- start asserted in DONE is ignored; it is accepted only in the following IDLE cycle.
- Reset mid-CALC aborts immediately to IDLE; no done is issued.

Optional Feature:
- Macro ALU_MC_DIV_EN.
- Defined: divu (1001) is implemented as above.
- Undefined: 1001 falls into the default case (ALU=B, 1-cycle latency, div_zero stays 0). No divider datapath is synthesised.

Test Plan:
- Reset asserted mid-mulu → all outputs at reset values, busy=0. Next start with add 5+3 → ALU=8, done 1 cycle later.
- add 0x7FFFFFFF+1 → ALU=0x80000000, carrier=0, Zero=0. sub 5-5 → ALU=0, Zero=1. or 0xF0|0x0F → 0xFF.
- mulu 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, ALU=0x00000001, done exactly 33 cycles after start. Second start pulsed while busy → ignored.
- divu 100/7 → ALU=14, hi=2, div_zero=0. divu 9/0 → ALU=0xFFFFFFFF, hi=9, div_zero=1, done after 1 cycle.
- slt -1<1 → 1. sll 1 by 31 → 0x80000000. srl 0x80000000 by 4 → 0x08000000. Code 1111 with B=0x1234 → ALU=0x1234.
- Without ALU_MC_DIV_EN: divu 100/7 → ALU=7, done after 1 cycle.
